// File: rtl/cache_pkg.sv
// Shared types and constants for the cache miss/fill controllers.
package cache_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      FILL = 1'b1
   } fill_state_t;

   localparam int          BLOCK_BYTES = 16;
   localparam int          OFFSET_W    = 3;
   localparam int          CNT_W       = 4;
   localparam logic [15:0] BLOCK_MASK  = 16'hFFF0;
   localparam logic [CNT_W-1:0] BLOCK_CNT = 4'd8;

endpackage

// File: rtl/fill_counter.sv
// 4-bit up-counter that saturates at SAT, with synchronous clear and enable.
module fill_counter
   import cache_pkg::*;
#(
   parameter logic [CNT_W-1:0] SAT = BLOCK_CNT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             en,
   output logic [CNT_W-1:0] cnt
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en && (cnt < SAT)) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss controller: issues one word request per cycle for a 16-byte block
// and streams returned words into the data array, writing the tag with the last word.
module cache_fill_fsm
   import cache_pkg::*;
#(
   parameter int BLOCK_WORDS = 8,
   parameter int MEM_LATENCY = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                miss_detected,
   input  logic [15:0]         miss_address,
   input  logic [15:0]         memory_data,
   input  logic                memory_data_valid,
   output logic                fsm_busy,
   output logic                memory_req,
   output logic [15:0]         memory_address,
   output logic                write_data_array,
   output logic [OFFSET_W-1:0] fill_word,
   output logic [15:0]         fill_data,
   output logic                write_tag_array,
   output logic [15:0]         base
);

   if (BLOCK_WORDS != 8) begin : g_bad_block_words
      $error("cache_fill_fsm: BLOCK_WORDS must be 8");
   end
   if (MEM_LATENCY < 1) begin : g_bad_mem_latency
      $error("cache_fill_fsm: MEM_LATENCY must be at least 1");
   end

   localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(BLOCK_WORDS - 1);

   fill_state_t      state;
   logic [CNT_W-1:0] issue_cnt;
   logic [CNT_W-1:0] recv_cnt;
   logic [15:0]      base_q;
   logic             start;
   logic             last_word;

   assign start = (state == IDLE) && miss_detected;

   fill_counter #(.SAT(BLOCK_CNT)) u_issue_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (start),
      .en    (memory_req),
      .cnt   (issue_cnt)
   );

   fill_counter #(.SAT(BLOCK_CNT)) u_recv_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (start),
      .en    (write_data_array),
      .cnt   (recv_cnt)
   );

   // Everything except fill_data is decoded from state and counters, never from miss_detected.
   assign fsm_busy         = (state == FILL);
   assign memory_req       = (state == FILL) && (issue_cnt < BLOCK_CNT);
   assign memory_address   = memory_req ? (base_q + {11'd0, issue_cnt, 1'b0}) : '0;
   assign write_data_array = (state == FILL) && memory_data_valid && (recv_cnt < BLOCK_CNT);
   assign fill_word        = write_data_array ? recv_cnt[OFFSET_W-1:0] : '0;
   assign fill_data        = memory_data;
   assign last_word        = write_data_array && (recv_cnt == LAST_WORD);
   assign write_tag_array  = last_word;
   assign base             = base_q;

   // base is cleared on return to IDLE so every output reads 0 while idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         base_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (miss_detected) begin
                  state  <= FILL;
                  base_q <= miss_address & BLOCK_MASK;
               end
            end
            FILL: begin
               if (last_word) begin
                  state  <= IDLE;
                  base_q <= '0;
               end
            end
            default: begin
               state  <= IDLE;
               base_q <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Directed/randomized bench for cache_fill_fsm with an in-order pipelined memory model.
module tb_cache_fill_fsm;

   logic        clk;
   logic        rst_n;
   logic        miss_detected;
   logic [15:0] miss_address;
   logic [15:0] memory_data;
   logic        memory_data_valid;
   logic        fsm_busy;
   logic        memory_req;
   logic [15:0] memory_address;
   logic        write_data_array;
   logic [2:0]  fill_word;
   logic [15:0] fill_data;
   logic        write_tag_array;
   logic [15:0] base;

   int tests;
   int fails;
   int cyc;

   // Memory model: outstanding requests returned in order at their ready cycle.
   logic [15:0] pend_addr[$];
   logic [15:0] pend_data[$];
   int          pend_time[$];
   int          last_ready;

   cache_fill_fsm #(.BLOCK_WORDS(8), .MEM_LATENCY(4)) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .miss_detected     (miss_detected),
      .miss_address      (miss_address),
      .memory_data       (memory_data),
      .memory_data_valid (memory_data_valid),
      .fsm_busy          (fsm_busy),
      .memory_req        (memory_req),
      .memory_address    (memory_address),
      .write_data_array  (write_data_array),
      .fill_word         (fill_word),
      .fill_data         (fill_data),
      .write_tag_array   (write_tag_array),
      .base              (base)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: observed no completion, required finish before time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"}, fsm_busy, 0);
      chk({tag, "_req"}, memory_req, 0);
      chk({tag, "_addr"}, memory_address, 0);
      chk({tag, "_wr"}, write_data_array, 0);
      chk({tag, "_word"}, fill_word, 0);
      chk({tag, "_tag"}, write_tag_array, 0);
      chk({tag, "_base"}, base, 0);
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         step();
         miss_detected     = 1'b0;
         memory_data_valid = 1'b0;
         memory_data       = 16'($urandom);
         #1;
         chk("idle_busy", fsm_busy, 0);
      end
   endtask

   // One complete fill. Latency of each word is drawn from [lat_lo, lat_hi];
   // abort_after > 0 drops rst_n asynchronously once that many words are written.
   task automatic run_fill(input logic [15:0] addr, input int lat_lo, input int lat_hi,
                           input bit keep_miss, input int abort_after);
      int          t, n_iss, n_recv, n_req_seen, guard, lat, r;
      int          first_req, last_req, first_wr, tag_cyc;
      bit          done, vld, aborted;
      logic [15:0] b, vdata, vaddr;

      b = addr & 16'hFFF0;
      miss_address      = addr;
      miss_detected     = 1'b1;
      memory_data_valid = 1'b0;
      #1;
      chk("miss_cycle_busy", fsm_busy, 0);
      chk("miss_cycle_req", memory_req, 0);
      t = cyc;
      n_iss = 0; n_recv = 0; n_req_seen = 0; guard = 0;
      first_req = -1; last_req = -1; first_wr = -1; tag_cyc = -1;
      done = 1'b0; aborted = 1'b0; last_ready = 0;
      vdata = '0; vaddr = '0;
      step();
      while (!done && guard < 60) begin
         vld = 1'b0;
         if (pend_time.size() > 0 && pend_time[0] <= cyc) begin
            vld   = 1'b1;
            vdata = pend_data.pop_front();
            vaddr = pend_addr.pop_front();
            void'(pend_time.pop_front());
         end
         memory_data_valid = vld;
         memory_data       = vld ? vdata : 16'($urandom);
         miss_address      = 16'($urandom);
         #1;
         chk("busy", fsm_busy, 1);
         chk("base", base, b);
         chk("req", memory_req, n_iss < 8);
         if (n_iss < 8) chk("req_addr", memory_address, b + 16'(2 * n_iss));
         chk("fill_data", fill_data, memory_data);
         chk("wr", write_data_array, vld);
         chk("tag", write_tag_array, vld && (n_recv == 7));
         if (vld) begin
            chk("fill_word", fill_word, n_recv);
            chk("word_addr", vaddr, b + 16'(2 * n_recv));
            if (first_wr < 0) first_wr = cyc;
         end
         if (memory_req) begin
            lat = $urandom_range(lat_hi, lat_lo);
            r   = cyc + lat;
            if (r <= last_ready) r = last_ready + 1;
            last_ready = r;
            pend_addr.push_back(memory_address);
            pend_data.push_back(16'($urandom));
            pend_time.push_back(r);
            n_req_seen++;
            if (first_req < 0) first_req = cyc;
            last_req = cyc;
         end
         if (n_iss < 8) n_iss++;
         if (vld) begin
            if (n_recv == 7) begin
               done    = 1'b1;
               tag_cyc = cyc;
            end
            n_recv++;
         end
         if (abort_after > 0 && n_recv == abort_after && !done) begin
            #1;
            rst_n = 1'b0;
            #1;
            chk_all_zero("async_rst");
            pend_addr.delete();
            pend_data.delete();
            pend_time.delete();
            miss_detected = 1'b0;
            aborted = 1'b1;
            done    = 1'b1;
         end else begin
            step();
            guard++;
         end
      end
      if (!done) chk("fill_timeout", 0, 1);
      if (!aborted && done) begin
         memory_data_valid = 1'b0;
         miss_detected     = keep_miss;
         #1;
         chk_all_zero("after_fill");
         chk("total_reqs", n_req_seen, 8);
         if (lat_lo == 4 && lat_hi == 4) begin
            chk("first_req_cycle", first_req, t + 1);
            chk("last_req_cycle", last_req, t + 8);
            chk("first_wr_cycle", first_wr, t + 5);
            chk("tag_cycle", tag_cyc, t + 12);
         end
      end
   endtask

   initial begin
      tests = 0;
      fails = 0;
      cyc   = 0;
      rst_n             = 1'b0;
      miss_detected     = 1'b0;
      miss_address      = 16'h0;
      memory_data       = 16'h1234;
      memory_data_valid = 1'b0;
      #3;
      chk_all_zero("reset");
      chk("reset_fill_data", fill_data, 16'h1234);
      step();
      step();
      rst_n = 1'b1;
      idle_cycles(2);

      // Aligned, unaligned and top-of-memory misses with fixed 4-cycle memory.
      run_fill(16'h0040, 4, 4, 1'b0, 0);
      idle_cycles(2);
      run_fill(16'h123B, 4, 4, 1'b0, 0);
      idle_cycles(2);
      run_fill(16'hFFFF, 4, 4, 1'b0, 0);
      idle_cycles(2);

      // Variable latency, random addresses.
      for (int i = 0; i < 4; i++) begin
         run_fill(16'($urandom), 4, 9, 1'b0, 0);
         idle_cycles(1 + $urandom_range(3, 0));
      end

      // Reset after 3 words, then stray valids while idle, then a clean refill.
      run_fill(16'h2468, 4, 6, 1'b0, 3);
      step();
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step();
         memory_data_valid = 1'b1;
         memory_data       = 16'($urandom);
         #1;
         chk("stray_wr", write_data_array, 0);
         chk("stray_busy", fsm_busy, 0);
         chk("stray_word", fill_word, 0);
      end
      memory_data_valid = 1'b0;
      run_fill(16'h2468, 4, 4, 1'b0, 0);
      idle_cycles(2);

      // Back-to-back: miss held across two blocks.
      run_fill(16'h0000, 4, 4, 1'b1, 0);
      run_fill(16'h0010, 4, 4, 1'b0, 0);
      idle_cycles(2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
